// File: rtl/alu_pkg.sv
// Shared types for the alu_seq datapath: function codes, status flags and
// the iterative-unit state encoding.
package alu_pkg;

  typedef enum logic [3:0] {
    FN_PASS = 4'd0,
    FN_ADD  = 4'd1,
    FN_SUB  = 4'd2,
    FN_AND  = 4'd3,
    FN_OR   = 4'd4,
    FN_XOR  = 4'd5,
    FN_NOT  = 4'd6,
    FN_SHL  = 4'd7,
    FN_SHR  = 4'd8,
    FN_ASR  = 4'd9,
    FN_INC  = 4'd10,
    FN_DEC  = 4'd11,
    FN_MUL  = 4'd12,
    FN_DIV  = 4'd13,
    FN_MOD  = 4'd14,
    FN_CMP  = 4'd15
  } fn_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  function automatic logic is_iter(fn_e f);
    return (f == FN_MUL) || (f == FN_DIV) || (f == FN_MOD);
  endfunction

endpackage

// File: rtl/alu_muldiv_unit.sv
// Iterative W-step shift-add multiplier / restoring divider for alu_seq.
// Only instantiated when ALU_MULDIV_EN is defined.
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | one multiply/divide step per edge, cnt_q counts down to 0
// FIN   | result written last edge; done_o high; may accept a new start
module alu_muldiv_unit
  import alu_pkg::*;
#(
  parameter int W     = 10,
  parameter int CNT_W = $clog2(W) + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  fn_e          fn_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] op_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         wr_o,
  output logic [W-1:0] res_o,
  output flags_t       flags_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     acc_q, acc_d;   // product high half / partial remainder
  logic [W-1:0]     lo_q, lo_d;     // multiplier / dividend-then-quotient
  logic [W-1:0]     opnd_q, opnd_d; // multiplicand / divisor
  fn_e              fn_q, fn_d;

  logic [W:0]   mul_sum;
  logic [W:0]   div_sh;
  logic         div_ge;
  logic [W-1:0] div_df;
  logic [W-1:0] step_acc, step_lo;

  assign mul_sum = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_sh  = {acc_q, lo_q[W-1]};
  assign div_ge  = div_sh >= {1'b0, opnd_q};
  assign div_df  = div_sh[W-1:0] - opnd_q;

  always_comb begin
    step_acc = '0;
    step_lo  = '0;
    if (fn_q == FN_MUL) begin
      step_acc = mul_sum[W:1];
      step_lo  = {mul_sum[0], lo_q[W-1:1]};
    end else begin
      step_acc = div_ge ? div_df : div_sh[W-1:0];
      step_lo  = {lo_q[W-2:0], div_ge};
    end
  end

  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      fn_q    <= FN_MUL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      fn_q    <= fn_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    fn_d    = fn_q;
    wr_o    = 1'b0;
    case (state_q)
      ST_IDLE, ST_FIN: begin
        state_d = ST_IDLE;
        if (start_i) begin
          state_d = ST_RUN;
          cnt_d   = CNT_W'(W - 1);
          fn_d    = fn_i;
          acc_d   = '0;
          lo_d    = (fn_i == FN_MUL) ? op_i : a_i;
          opnd_d  = (fn_i == FN_MUL) ? a_i : op_i;
        end
      end
      ST_RUN: begin
        acc_d = step_acc;
        lo_d  = step_lo;
        if (cnt_q == '0) begin
          state_d = ST_FIN;
          wr_o    = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Result and flags are taken from the final step so they land on the same edge.
  always_comb begin
    res_o     = (fn_q == FN_MOD) ? step_acc : step_lo;
    flags_o.z = (res_o == '0);
    flags_o.n = res_o[W-1];
    flags_o.c = 1'b0;
    flags_o.v = (fn_q == FN_MUL) ? (step_acc != '0) : (opnd_q == '0);
  end

  assign busy_o = (state_q == ST_RUN);
  assign done_o = (state_q == ST_FIN);

endmodule

// File: rtl/alu_seq.sv
// Multi-stage ALU: A operand register, G result register, flags, tri-state Q.
// Define ALU_MULDIV_EN to enable the iterative MUL/DIV/MOD unit.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W     = 10,
  parameter int CNT_W = $clog2(W) + 1
) (
  input  logic         CLKb,
  input  logic         Rst,
  input  logic [W-1:0] OP,
  input  logic [3:0]   FN,
  input  logic         Ain,
  input  logic         Gin,
  input  logic         Gout,
  output logic [W-1:0] Q,
  output logic [3:0]   Flags,
  output logic         Busy,
  output logic         Done
);

  logic [W-1:0]     a_q, g_q;
  flags_t           flags_q;
  fn_e              fn;
  logic [CNT_W-1:0] amt;
  logic [W:0]       add_x, sub_x, inc_x, dec_x, shl_x, shr_x, asr_x;
  logic [W-1:0]     r;
  logic             c, v;
  flags_t           alu_f;
  logic             iter_fn, md_wr;
  logic [W-1:0]     md_res;
  flags_t           md_flags;

  assign fn    = fn_e'(FN);
  assign amt   = OP[CNT_W-1:0];
  assign add_x = {1'b0, a_q} + {1'b0, OP};
  assign sub_x = {1'b0, a_q} + {1'b0, ~OP} + {{W{1'b0}}, 1'b1};
  assign inc_x = {1'b0, a_q} + {{W{1'b0}}, 1'b1};
  assign dec_x = {1'b0, a_q} + {1'b0, {W{1'b1}}};
  // One guard bit on each side catches the last bit shifted out.
  assign shl_x = {1'b0, a_q} << amt;
  assign shr_x = {a_q, 1'b0} >> amt;
  assign asr_x = $signed({a_q, 1'b0}) >>> amt;

  always_comb begin
    r = '0;
    c = 1'b0;
    v = 1'b0;
    case (fn)
      FN_PASS: r = OP;
      FN_ADD: begin
        r = add_x[W-1:0];
        c = add_x[W];
        v = (a_q[W-1] == OP[W-1]) && (r[W-1] != a_q[W-1]);
      end
      FN_SUB, FN_CMP: begin
        r = sub_x[W-1:0];
        c = sub_x[W];
        v = (a_q[W-1] != OP[W-1]) && (r[W-1] != a_q[W-1]);
      end
      FN_AND: r = a_q & OP;
      FN_OR:  r = a_q | OP;
      FN_XOR: r = a_q ^ OP;
      FN_NOT: r = ~a_q;
      FN_SHL: begin
        r = shl_x[W-1:0];
        c = shl_x[W];
      end
      FN_SHR: begin
        r = shr_x[W:1];
        c = shr_x[0];
      end
      FN_ASR: begin
        r = asr_x[W:1];
        c = asr_x[0];
      end
      FN_INC: begin
        r = inc_x[W-1:0];
        c = inc_x[W];
        v = ~a_q[W-1] & r[W-1];
      end
      FN_DEC: begin
        r = dec_x[W-1:0];
        c = dec_x[W];
        v = a_q[W-1] & ~r[W-1];
      end
      default: r = '0;
    endcase
    alu_f.z = (r == '0);
    alu_f.n = r[W-1];
    alu_f.c = c;
    alu_f.v = v;
`ifndef ALU_MULDIV_EN
    if (is_iter(fn)) alu_f = '{z: 1'b1, n: 1'b0, c: 1'b0, v: 1'b1};
`endif
  end

`ifdef ALU_MULDIV_EN
  assign iter_fn = is_iter(fn);

  alu_muldiv_unit #(.W(W), .CNT_W(CNT_W)) u_muldiv (
    .clk_i   (CLKb),
    .rst_i   (Rst),
    .start_i (Gin && iter_fn && !Busy),
    .fn_i    (fn),
    .a_i     (a_q),
    .op_i    (OP),
    .busy_o  (Busy),
    .done_o  (Done),
    .wr_o    (md_wr),
    .res_o   (md_res),
    .flags_o (md_flags)
  );
`else
  assign iter_fn  = 1'b0;
  assign Busy     = 1'b0;
  assign Done     = 1'b0;
  assign md_wr    = 1'b0;
  assign md_res   = '0;
  assign md_flags = '0;
`endif

  always_ff @(negedge CLKb) begin
    if (Rst) begin
      a_q     <= '0;
      g_q     <= '0;
      flags_q <= '0;
    end else begin
      if (Ain && !Busy) a_q <= OP;
      if (md_wr) begin
        g_q     <= md_res;
        flags_q <= md_flags;
      end else if (Gin && !Busy && !iter_fn) begin
        if (fn != FN_CMP) g_q <= r;
        flags_q <= alu_f;
      end
    end
  end

  assign Q     = Gout ? g_q : {W{1'bz}};
  assign Flags = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: driver pushes expected G/Flags from an
// arithmetic reference model; a monitor pops on each observed result.
module tb_alu_seq;

  localparam int W     = 10;
  localparam int CNT_W = $clog2(W) + 1;
  localparam int M     = (1 << W) - 1;

  typedef struct {
    int         g;
    logic [3:0] f;
  } exp_t;

  logic         clk = 1'b1;
  logic         rst, ain, gin, gout;
  logic [W-1:0] op;
  logic [3:0]   fn;
  wire  [W-1:0] q;
  logic [3:0]   flags;
  logic         busy, done;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   m_a, m_g;

  alu_seq #(.W(W)) dut (
    .CLKb  (clk),
    .Rst   (rst),
    .OP    (op),
    .FN    (fn),
    .Ain   (ain),
    .Gin   (gin),
    .Gout  (gout),
    .Q     (q),
    .Flags (flags),
    .Busy  (busy),
    .Done  (done)
  );

  always #5 clk = ~clk;

  function automatic bit tb_iter(input int f);
`ifdef ALU_MULDIV_EN
    return (f >= 12) && (f <= 14);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int sgn(input int x);
    return ((x >> (W - 1)) & 1) != 0 ? x - (1 << W) : x;
  endfunction

  function automatic bit oor(input int x);
    return (x > (1 << (W - 1)) - 1) || (x < -(1 << (W - 1)));
  endfunction

  function automatic void ref_op(input int a, input int o, input int f, input int g_old,
                                 output int g, output logic [3:0] fl);
    int r, c, v, amt, sa, so, s, msb;
    r = 0; c = 0; v = 0;
    amt = o % (1 << CNT_W);
    sa = sgn(a); so = sgn(o); msb = (a >> (W - 1)) & 1;
    case (f)
      0:  r = o;
      1:  begin s = a + o; r = s & M; c = s >> W; v = oor(sa + so); end
      2, 15: begin r = (a - o) & M; c = (a >= o); v = oor(sa - so); end
      3:  r = a & o;
      4:  r = a | o;
      5:  r = a ^ o;
      6:  r = ~a & M;
      7:  begin
            r = (amt >= W) ? 0 : (a << amt) & M;
            c = (amt >= 1 && amt <= W) ? (a >> (W - amt)) & 1 : 0;
          end
      8:  begin
            r = (amt >= W) ? 0 : a >> amt;
            c = (amt >= 1 && amt <= W) ? (a >> (amt - 1)) & 1 : 0;
          end
      9:  begin
            r = (sa >>> amt) & M;
            c = (amt == 0) ? 0 : (amt <= W) ? (a >> (amt - 1)) & 1 : msb;
          end
      10: begin r = (a + 1) & M; c = (a + 1) >> W; v = oor(sa + 1); end
      11: begin r = (a - 1) & M; c = (a >= 1); v = oor(sa - 1); end
      12: begin s = a * o; r = s & M; v = (s >> W) != 0; end
      13: begin if (o == 0) begin r = M; v = 1; end else r = a / o; end
      14: begin if (o == 0) begin r = a; v = 1; end else r = a % o; end
      default: r = 0;
    endcase
    g = (f == 15) ? g_old : r;
    fl[3] = (r == 0);
    fl[2] = ((r >> (W - 1)) & 1) != 0;
    fl[1] = (c != 0);
    fl[0] = (v != 0);
`ifndef ALU_MULDIV_EN
    if (f >= 12 && f <= 14) begin
      g  = 0;
      fl = 4'b1001;
    end
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_a(input int v);
    op = W'(v); ain = 1'b1; gin = 1'b0;
    tick();
    ain = 1'b0;
    m_a = v;
  endtask

  // Keeps poking Gin/Ain while busy; the DUT must ignore all of it.
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 4 * W) begin
      gin = 1'b1; ain = 1'b1;
      fn  = 4'($urandom_range(0, 15));
      op  = W'($urandom_range(0, M));
      tick();
      n++;
    end
    gin = 1'b0; ain = 1'b0;
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL busy_timeout: busy still %0b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic issue(input int f, input int o, input bit ld, input bit wt);
    exp_t e;
    ref_op(m_a, o, f, m_g, e.g, e.f);
    sb.push_back(e);
    m_g = e.g;
    fn = 4'(f); op = W'(o); gin = 1'b1; ain = ld;
    tick();
    gin = 1'b0; ain = 1'b0;
    if (ld) m_a = o;
    if (wt && tb_iter(f)) wait_idle();
  endtask

  // Monitor: sampled mid-cycle, inputs still hold the values seen at the last negedge.
  initial begin
    bit   prev_busy = 1'b0;
    int   busy_cnt  = 0;
    bit   fire;
    exp_t e;
    forever begin
      @(posedge clk);
      if (rst) begin
        busy_cnt  = 0;
        prev_busy = busy;
      end else begin
        fire = (gin && !prev_busy && !tb_iter(int'(fn))) || done;
        if (done) begin
          checks++;
          if (busy_cnt != W) begin
            errors++;
            $display("FAIL busy_len: busy lasted %0d cycles, required %0d", busy_cnt, W);
          end
        end
        if (fire) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_result: G=0x%0h flags=%b with nothing expected", q, flags);
          end else begin
            e = sb.pop_front();
            if (int'(q) !== e.g || flags !== e.f) begin
              errors++;
              $display("FAIL result: got G=0x%0h flags=%b, expected G=0x%0h flags=%b",
                       q, flags, e.g, e.f);
            end
          end
        end
        busy_cnt  = busy ? busy_cnt + 1 : 0;
        prev_busy = busy;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; gin = 1'b0; ain = 1'b0; gout = 1'b1; fn = '0; op = '0;
    tick(); tick();
    rst = 1'b0; m_a = 0; m_g = 0;
    chk("reset_q", int'(q), 0);
    chk("reset_flags", int'(flags), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);

    load_a(M);
    issue(1, 1, 0, 1);
    chk("add_wrap_q", int'(q), 0);

    load_a(3);
    issue(2, 5, 0, 1);
    gout = 1'b0;
    #1;
    checks++;
    if (q === W'(m_g)) begin
      errors++;
      $display("FAIL q_released: got Q=0x%0h with Gout=0, required high-Z", q);
    end
    gout = 1'b1;
    #1;

    load_a(5);
    issue(15, 5, 0, 1);
    issue(1, 7, 1, 1);
    issue(1, 0, 0, 1);

    load_a(5);
    issue(12, 7, 0, 1);
    issue(1, 0, 0, 1);

    load_a(100);
    issue(13, 7, 0, 1);
    issue(14, 7, 0, 1);
    issue(13, 0, 0, 1);
    issue(14, 0, 0, 1);

    load_a(12'h200);
    issue(9, 3, 0, 1);
    issue(7, 12, 0, 1);
    issue(8, 10, 0, 1);
    issue(10, 0, 0, 1);

    load_a(5);
    issue(12, 7, 0, 0);
    tick(); tick(); tick();
`ifdef ALU_MULDIV_EN
    chk("busy_before_abort", int'(busy), 1);
`endif
    sb.delete();
    rst = 1'b1;
    tick();
    rst = 1'b0; m_a = 0; m_g = 0;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_q", int'(q), 0);
    repeat (2 * W) tick();
    load_a(9);
    issue(1, 4, 0, 1);

    for (int i = 0; i < 150; i++) begin
      int f, o;
      f = $urandom_range(0, 15);
      o = $urandom_range(0, M);
      if ($urandom_range(0, 5) == 0) o = $urandom_range(0, 2 * W);
      if ($urandom_range(0, 7) == 0) load_a($urandom_range(0, M));
      issue(f, o, $urandom_range(0, 3) == 0, 1);
    end

    tick(); tick();
    chk("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
